rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 38 +++
 rtl/rst_sync.sv | 34 +++
 rtl/rst_seq.sv | 156 +++++++++++++++
 tb/tb_rst_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_pkg
//  Description : Shared types and constants for the reset sequencer.
//                Holds the sequencer state encoding, default parameter
//                values and the delay/hold counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    // Width of the delay/hold counter and of the soft-reset counter.
    localparam int c_cnt_w = 8;

    // Default parameter values for rst_seq.
    localparam int c_def_sync_stages = 2;
    localparam int c_def_dly0        = 16;
    localparam int c_def_dly1        = 32;
    localparam int c_def_dly2        = 64;
    localparam int c_def_hold_cyc    = 8;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_ASSERT = 3'd0,
        ST_WAIT0  = 3'd1,
        ST_WAIT1  = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_RUN    = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

    // Counter value on which a wait of 'cycles' edges completes
    // (the counter starts at 0, so the last edge sees cycles-1).
    function automatic logic [c_cnt_w-1:0] term_count(input int cycles);
        return c_cnt_w'(cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rst_sync
//  Description : Async-assert / sync-deassert reset synchronizer.
//                The chain clears immediately on RST and shifts in a 1 on
//                each rising edge, so rst_sync_n rises on the
//                SYNC_STAGES-th edge after RST falls.
//  Ports       : clk_rc     - clock
//                RST        - asynchronous active-high reset
//                rst_sync_n - synchronized active-low reset
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_rc,
    input  logic RST,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk_rc or posedge RST) begin
        if (RST) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq
//  Description : Staged reset sequencer. After the synchronized reset
//                releases, three downstream active-low resets are released
//                in order 0,1,2 with programmable gaps. In RUN a software
//                request re-asserts all stages for HOLD_CYC cycles and the
//                release sequence repeats.
//  Ports       : clk_rc       - clock
//                RST          - asynchronous active-high reset
//                soft_rst_req - synchronous software reset request
//                rst_n_out    - per-stage active-low resets (bit 0 first)
//                rst_done     - high when all three stages are released
//                soft_rst_cnt - accepted soft resets, saturating at 255
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = c_def_sync_stages,
    parameter int DLY0        = c_def_dly0,
    parameter int DLY1        = c_def_dly1,
    parameter int DLY2        = c_def_dly2,
    parameter int HOLD_CYC    = c_def_hold_cyc
) (
    input  logic               clk_rc,
    input  logic               RST,
    input  logic               soft_rst_req,
    output logic [2:0]         rst_n_out,
    output logic               rst_done,
    output logic [c_cnt_w-1:0] soft_rst_cnt
);

    localparam logic [c_cnt_w-1:0] c_last0    = term_count(DLY0);
    localparam logic [c_cnt_w-1:0] c_last1    = term_count(DLY1);
    localparam logic [c_cnt_w-1:0] c_last2    = term_count(DLY2);
    localparam logic [c_cnt_w-1:0] c_lasthold = term_count(HOLD_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = {c_cnt_w{1'b1}};

    logic               w_sync_n;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_rst_n;
    logic               r_done;
    logic [c_cnt_w-1:0] r_soft_cnt;

    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         w_rst_n_nxt;
    logic               w_done_nxt;
    logic [c_cnt_w-1:0] w_soft_cnt_nxt;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_rc     (clk_rc),
        .RST        (RST),
        .rst_sync_n (w_sync_n)
    );

    always_ff @(posedge clk_rc or posedge RST) begin
        if (RST) begin
            r_state    <= ST_ASSERT;
            r_cnt      <= '0;
            r_rst_n    <= 3'b000;
            r_done     <= 1'b0;
            r_soft_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_done     <= w_done_nxt;
            r_soft_cnt <= w_soft_cnt_nxt;
        end
    end

    // Outputs are updated only alongside state transitions, so each
    // rst_n_out bit changes at most once per sequence and never glitches.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rst_n_nxt    = r_rst_n;
        w_done_nxt     = r_done;
        w_soft_cnt_nxt = r_soft_cnt;

        case (r_state)
            ST_ASSERT: begin
                if (w_sync_n) begin
                    w_state_nxt = ST_WAIT0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT0: begin
                if (r_cnt == c_last0) begin
                    w_rst_n_nxt[0] = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_WAIT1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_WAIT1: begin
                if (r_cnt == c_last1) begin
                    w_rst_n_nxt[1] = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_WAIT2;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_WAIT2: begin
                if (r_cnt == c_last2) begin
                    w_rst_n_nxt[2] = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // Only RUN listens to the request; elsewhere it is dropped.
                if (soft_rst_req) begin
                    w_rst_n_nxt = 3'b000;
                    w_done_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HOLD;
                    if (r_soft_cnt != c_cnt_max) begin
                        w_soft_cnt_nxt = r_soft_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (r_cnt == c_lasthold) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ASSERT;
                w_cnt_nxt   = '0;
                w_rst_n_nxt = 3'b000;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    assign rst_n_out    = r_rst_n;
    assign rst_done     = r_done;
    assign soft_rst_cnt = r_soft_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_seq
//  Description : Scoreboard bench for rst_seq. Stimulus pushes every output
//                change it expects (cycle number and values) into a queue;
//                a monitor pops and compares on every observed change of
//                the outputs or on an explicit probe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq;

    logic       clk_rc;
    logic       RST;
    logic       soft_rst_req;
    logic [2:0] rst_n_out;
    logic       rst_done;
    logic [7:0] soft_rst_cnt;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    logic r_probe;

    typedef struct {
        int         cyc;
        logic [2:0] rn;
        logic       done;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    exp_t q[$];

    rst_seq u_dut (
        .clk_rc       (clk_rc),
        .RST          (RST),
        .soft_rst_req (soft_rst_req),
        .rst_n_out    (rst_n_out),
        .rst_done     (rst_done),
        .soft_rst_cnt (soft_rst_cnt)
    );

    initial clk_rc = 1'b0;
    always #5 clk_rc = ~clk_rc;

    initial cyc = 0;
    always @(posedge clk_rc) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] rn, input logic d,
                        input logic [7:0] n, input string tag);
        exp_t e;
        e.cyc  = c;
        e.rn   = rn;
        e.done = d;
        e.cnt  = n;
        e.tag  = tag;
        q.push_back(e);
    endtask

    // Release sequence after RST falls with the counter at 'base'.
    task automatic push_seq(input int base, input logic [7:0] n);
        push(base + 19,  3'b001, 1'b0, n, "rel0");
        push(base + 51,  3'b011, 1'b0, n, "rel1");
        push(base + 115, 3'b111, 1'b1, n, "rel2");
    endtask

    // Accepted soft reset on edge e, then hold and re-release.
    task automatic push_soft(input int e, input logic [7:0] n);
        push(e,       3'b000, 1'b0, n, "soft_assert");
        push(e + 24,  3'b001, 1'b0, n, "soft_rel0");
        push(e + 56,  3'b011, 1'b0, n, "soft_rel1");
        push(e + 120, 3'b111, 1'b1, n, "soft_rel2");
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk_rc);
            #2;
        end
    endtask

    // Called at posedge+2 while in RUN; returns the accepting edge number.
    task automatic soft_pulse(input logic [7:0] n, output int e);
        soft_rst_req = 1'b1;
        e = cyc + 1;
        push_soft(e, n);
        @(posedge clk_rc);
        #2;
        soft_rst_req = 1'b0;
    endtask

    // Monitor: compare against the scoreboard 1 ns after any output change.
    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        #1;
        forever begin
            @(rst_n_out or rst_done or soft_rst_cnt or r_probe);
            #1;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: cyc=%0d out=%b done=%b cnt=%0d, none expected",
                         cyc, rst_n_out, rst_done, soft_rst_cnt);
            end else begin
                e = q.pop_front();
                if (cyc !== e.cyc || rst_n_out !== e.rn || rst_done !== e.done ||
                    soft_rst_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s: got cyc=%0d out=%b done=%b cnt=%0d, expected cyc=%0d out=%b done=%b cnt=%0d",
                             e.tag, cyc, rst_n_out, rst_done, soft_rst_cnt,
                             e.cyc, e.rn, e.done, e.cnt);
                end
            end
        end
    end

    initial begin
        int   base;
        int   e;
        exp_t left;
        RST          = 1'b1;
        soft_rst_req = 1'b0;
        r_probe      = 1'b0;

        // Power-on: reset values while RST is held, then full release.
        repeat (5) @(posedge clk_rc);
        #2;
        push(cyc, 3'b000, 1'b0, 8'd0, "reset_state");
        r_probe = ~r_probe;
        #1;
        RST  = 1'b0;
        base = cyc;
        push_seq(base, 8'd0);
        wait_cyc(base + 116);

        // Single soft reset.
        soft_pulse(8'd1, e);
        wait_cyc(e + 121);

        // Request held through WAIT1 is ignored; first RUN edge takes it.
        push(cyc, 3'b000, 1'b0, 8'd0, "rst_clear");
        RST = 1'b1;
        repeat (3) @(posedge clk_rc);
        #2;
        RST  = 1'b0;
        base = cyc;
        push_seq(base, 8'd0);
        wait_cyc(base + 30);
        soft_rst_req = 1'b1;
        push_soft(base + 116, 8'd1);
        wait_cyc(base + 116);
        soft_rst_req = 1'b0;
        wait_cyc(base + 116 + 121);

        // Abort at edge 40: outputs clear at once, then a clean restart.
        push(cyc, 3'b000, 1'b0, 8'd0, "rst_clear2");
        RST = 1'b1;
        repeat (3) @(posedge clk_rc);
        #2;
        RST  = 1'b0;
        base = cyc;
        push_seq(base, 8'd0);
        wait_cyc(base + 19);
        // Drop the two later releases: the abort comes first.
        void'(q.pop_back());
        void'(q.pop_back());
        wait_cyc(base + 40);
        push(cyc, 3'b000, 1'b0, 8'd0, "abort");
        RST = 1'b1;
        repeat (2) @(posedge clk_rc);
        #2;
        RST  = 1'b0;
        base = cyc;
        push_seq(base, 8'd0);
        wait_cyc(base + 116);

        // Short RST glitch after a soft reset clears everything.
        soft_pulse(8'd1, e);
        wait_cyc(e + 121);
        @(posedge clk_rc);
        #3;
        push(cyc, 3'b000, 1'b0, 8'd0, "glitch");
        RST = 1'b1;
        #3;
        RST  = 1'b0;
        base = cyc;
        push_seq(base, 8'd0);
        wait_cyc(base + 116);

        // Saturation of the soft reset counter.
        for (int i = 0; i < 260; i++) begin
            soft_pulse((i < 255) ? 8'(i + 1) : 8'd255, e);
            wait_cyc(e + 121);
        end
        push(cyc, 3'b000, 1'b0, 8'd0, "sat_clear");
        RST = 1'b1;
        repeat (2) @(posedge clk_rc);
        #2;
        RST  = 1'b0;
        base = cyc;
        push_seq(base, 8'd0);
        wait_cyc(base + 120);

        #5;
        while (q.size() > 0) begin
            left = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: not observed, expected cyc=%0d out=%b done=%b cnt=%0d",
                     left.tag, left.cyc, left.rn, left.done, left.cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
